// File: rtl/riscv_pkg.sv
// Shared types and constants for the pipelined RISC-V core.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    KILL
  } fetch_state_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding buffer for an instruction and its PC, used while decode is stalled.
module fetch_skid_buffer
  import riscv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_full,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_full;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full  <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_full  = r_full;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with a single-outstanding req/gnt/rvalid port and the IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_t r_state;
  logic [31:0]  r_pcf;
  logic [31:0]  r_pend_pc;
  logic [31:0]  r_instr_d;
  logic [31:0]  r_pc_d;
  logic [31:0]  r_pc_plus4_d;
  logic         r_valid_d;

  logic         w_rsp;
  logic         w_req;
  logic         w_fire;
  logic         w_skid_full;
  logic         w_skid_load;
  logic         w_skid_clear;
  logic [31:0]  w_skid_instr;
  logic [31:0]  w_skid_pc;

  // A live response is only one returning for a WAIT request; IDLE/KILL rvalids are dropped.
  assign w_rsp  = (r_state == WAIT) && imem_rvalid;
  assign w_req  = !StallF && !PCSrcE && !w_skid_full &&
                  ((r_state == IDLE) || (w_rsp && !StallD));
  assign w_fire = w_req && imem_gnt;

  assign w_skid_load  = w_rsp && StallD && !PCSrcE;
  assign w_skid_clear = PCSrcE || (w_skid_full && !FlushD && !StallD);

  fetch_skid_buffer u_skid (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_instr (imem_rdata),
    .i_pc    (r_pend_pc),
    .o_full  (w_skid_full),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_pcf     <= RESET_PC;
      r_pend_pc <= '0;
    end else if (PCSrcE) begin
      r_pcf <= PCTargetE;
      unique case (r_state)
        WAIT, KILL: r_state <= imem_rvalid ? IDLE : KILL;
        default:    r_state <= IDLE;
      endcase
    end else if (w_fire) begin
      r_pend_pc <= r_pcf;
      r_pcf     <= pc_plus4(r_pcf);
      r_state   <= WAIT;
    end else if (imem_rvalid && (r_state != IDLE)) begin
      r_state <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (FlushD) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (StallD) begin
      r_instr_d <= r_instr_d;
    end else if (w_skid_full) begin
      r_instr_d    <= w_skid_instr;
      r_pc_d       <= w_skid_pc;
      r_pc_plus4_d <= pc_plus4(w_skid_pc);
      r_valid_d    <= 1'b1;
    end else if (w_rsp && !PCSrcE) begin
      r_instr_d    <= imem_rdata;
      r_pc_d       <= r_pend_pc;
      r_pc_plus4_d <= pc_plus4(r_pend_pc);
      r_valid_d    <= 1'b1;
    end else begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pcf;
  assign InstrD    = r_instr_d;
  assign PCD       = r_pc_d;
  assign PCPlus4D  = r_pc_plus4_d;
  assign ValidD    = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0050_0093;
  localparam logic [31:0] I1  = 32'h00A0_0113;
  localparam logic [31:0] I2  = 32'h0020_8193;
  localparam logic [31:0] I3  = 32'h0031_00B3;
  localparam logic [31:0] I4  = 32'h4020_8233;
  localparam logic [31:0] I5  = 32'h0010_8093;
  localparam logic [31:0] I6  = 32'h0052_8293;
  localparam logic [31:0] I7  = 32'h0FF0_0313;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD)
  );

  typedef struct {
    logic        sf, sd, fd, pcs;
    logic [31:0] tgt;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr, e_instr, e_pcd, e_p4;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sf, sd, fd, pcs, input logic [31:0] tgt,
                              input logic gnt, rv, input logic [31:0] rdata,
                              input logic e_req, input logic [31:0] e_addr, e_instr,
                              e_pcd, e_p4, input logic e_valid);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fd = fd; v.pcs = pcs; v.tgt = tgt;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr;
    v.e_pcd = e_pcd; v.e_p4 = e_p4; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, step_no, act, exp);
    end
  endtask

  // Called at posedge+1: drive, check combinational request mid-cycle, then registered outputs.
  task automatic apply(input vec_t v);
    StallF = v.sf; StallD = v.sd; FlushD = v.fd; PCSrcE = v.pcs; PCTargetE = v.tgt;
    imem_gnt = v.gnt; imem_rvalid = v.rv; imem_rdata = v.rdata;
    #4;
    chk("imem_req", {31'd0, imem_req}, {31'd0, v.e_req});
    chk("imem_addr", imem_addr, v.e_addr);
    @(posedge clk);
    #1;
    chk("InstrD", InstrD, v.e_instr);
    chk("PCD", PCD, v.e_pcd);
    chk("PCPlus4D", PCPlus4D, v.e_p4);
    chk("ValidD", {31'd0, ValidD}, {31'd0, v.e_valid});
    step_no++;
  endtask

  initial begin
    reset = 1'b0;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;

    //        sf sd fd pcs tgt           gnt rv rdata  req addr          instr pcd           p4            v
    // streaming at one instruction per cycle
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0, 1, 32'h0,        NOP, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 1, I0,    1, 32'h4,        I0,  32'h0,        32'h4,        1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 1, I1,    1, 32'h8,        I1,  32'h4,        32'h8,        1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 1, I2,    1, 32'hC,        I2,  32'h8,        32'hC,        1));
    // load-use stall: 0xC response parks in skid, then drains
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        1, 1, I3,    0, 32'h10,       I2,  32'h8,        32'hC,        1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        1, 0, 32'h0, 0, 32'h10,       I2,  32'h8,        32'hC,        1));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        1, 0, 32'h0, 0, 32'h10,       I2,  32'h8,        32'hC,        1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0, 0, 32'h10,       I3,  32'hC,        32'h10,       1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0, 1, 32'h10,       NOP, 32'hC,        32'h10,       0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 1, I4,    1, 32'h14,       I4,  32'h10,       32'h14,       1));
    // redirect with 0x14 outstanding; its late response must be dropped
    vecs.push_back(mk(0, 0, 1, 1, 32'h100,      1, 0, 32'h0, 0, 32'h18,       NOP, 32'h10,       32'h14,       0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 1, BAD,   0, 32'h100,      NOP, 32'h10,       32'h14,       0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0, 1, 32'h100,      NOP, 32'h10,       32'h14,       0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 1, I5,    1, 32'h104,      I5,  32'h100,      32'h104,      1));
    // fill skid, then flush+redirect must clear it and allow an immediate request
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        1, 1, I6,    0, 32'h108,      I5,  32'h100,      32'h104,      1));
    vecs.push_back(mk(0, 0, 1, 1, 32'hFFFFFFFC, 1, 0, 32'h0, 0, 32'h108,      NOP, 32'h100,      32'h104,      0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0, 1, 32'hFFFFFFFC, NOP, 32'h100,      32'h104,      0));
    // response without grant: PC wrap shows up in PCPlus4D
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, I7,    1, 32'h0,        I7,  32'hFFFFFFFC, 32'h0,        1));
    // grant withheld: request and address held steady
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 0, 32'h0, 1, 32'h0,        NOP, 32'hFFFFFFFC, 32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0, 1, 32'h0,        NOP, 32'hFFFFFFFC, 32'h0,        0));

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_InstrD", InstrD, NOP);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_PCPlus4D", PCPlus4D, 32'h0);
    chk("rst_ValidD", {31'd0, ValidD}, 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Async reset while a request to 0x0 is outstanding, then a stale rvalid after release.
    reset = 1'b0;
    #1;
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_InstrD", InstrD, NOP);
    chk("midrst_PCD", PCD, 32'h0);
    chk("midrst_ValidD", {31'd0, ValidD}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply(mk(0, 0, 0, 0, 32'h0, 0, 1, BAD,   1, 32'h0, NOP, 32'h0, 32'h0, 0));
    apply(mk(0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0, NOP, 32'h0, 32'h0, 0));
    apply(mk(0, 0, 0, 0, 32'h0, 1, 1, I0,    1, 32'h4, I0,  32'h0, 32'h4, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
